inst_rom_arbiter: RTL and testbench

- Shares the single-port combinational instruction ROM between two requesters.
- Requester 0 is the IF stage (PC fetch). Requester 1 is a debug/loader read port, which can also serve literal reads from the code region.
- Fixed priority to IF, with a starvation counter that forces a debug grant after a bounded wait.
- Read data is registered, with a one-cycle valid pulse. A stall request is raised to ctrl whenever IF is denied.

---
 rtl/inst_rom_arbiter.sv | 107 ++++++++++
 tb/tb_inst_rom_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Two-requester arbiter for the single-port combinational instruction ROM.
// IF has fixed priority; a saturating starvation counter forces a debug grant after a bounded wait.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,

  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,

  output logic              addr_err,
  output logic              stallreq_if,

  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DBG
  } owner_e;

  owner_e            owner;
  logic [3:0]        starve_cnt;
  logic              force_dbg;
  logic              misaligned;
  logic [ADDR_W-1:0] gnt_addr;

  // Grants are suppressed during reset, so nothing granted in a reset cycle can produce a response.
  always_comb begin
    force_dbg = dbg_req & (starve_cnt == LIMIT);
    owner     = OWN_NONE;
    if (!rst) begin
      if (dbg_req && (force_dbg || !if_req)) begin
        owner = OWN_DBG;
      end else if (if_req) begin
        owner = OWN_IF;
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    unique case (owner)
      OWN_IF:   gnt_addr = if_addr;
      OWN_DBG:  gnt_addr = dbg_addr;
      default:  gnt_addr = '0;
    endcase
  end

  assign if_gnt      = (owner == OWN_IF);
  assign dbg_gnt     = (owner == OWN_DBG);
  assign rom_ce      = if_gnt | dbg_gnt;
  assign rom_addr    = gnt_addr;
  assign misaligned  = |gnt_addr[1:0];
  assign stallreq_if = if_req & ~if_gnt;

  // Any cycle where debug is not left waiting (granted or request dropped) restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (dbg_req && !dbg_gnt) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata   <= '0;
      dbg_rdata  <= '0;
      if_rvalid  <= 1'b0;
      dbg_rvalid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if_rvalid  <= if_gnt;
      dbg_rvalid <= dbg_gnt;
      addr_err   <= rom_ce & misaligned;
      if (if_gnt) begin
        if_rdata <= misaligned ? '0 : rom_inst;
      end
      if (dbg_gnt) begin
        dbg_rdata <= misaligned ? '0 : rom_inst;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Scoreboarded bench for inst_rom_arbiter: directed scenarios followed by randomized request traffic.
module tb_inst_rom_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, addr_err, stallreq_if, rom_ce;
  logic [31:0] if_rdata, dbg_rdata, rom_addr, rom_inst;

  always #5 clk = ~clk;

  inst_rom_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .addr_err(addr_err), .stallreq_if(stallreq_if),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  logic [31:0] mem [0:63];
  assign rom_inst = mem[rom_addr[7:2]];

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       if_q[$];
  resp_t       dbg_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          waited = 0;
  logic [31:0] if_hold = '0;
  logic [31:0] dbg_hold = '0;
  bit          mon_en = 1'b0;
  bit          if_won = 1'b0;
  bit          dbg_won = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 32'h0 : mem[a[7:2]];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // One clock cycle: apply inputs, judge the combinational outputs, and enqueue the responses due next cycle.
  task automatic drive(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [31:0] da);
    bit          dw, iw;
    logic [31:0] ga;
    @(posedge clk);
    cyc++;
    if (rst) begin
      if_hold  = '0;
      dbg_hold = '0;
    end
    #1;
    rst = r; if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
    #1;
    dw = !r && dr && (!ir || waited >= LIMIT);
    iw = !r && ir && !dw;
    ga = dw ? da : (iw ? ia : 32'h0);
    chk("if_gnt", 32'(if_gnt), 32'(iw));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(dw));
    chk("rom_ce", 32'(rom_ce), 32'(iw || dw));
    chk("rom_addr", rom_addr, ga);
    chk("stallreq_if", 32'(stallreq_if), 32'(ir && !iw));
    if (iw) if_q.push_back('{due: cyc + 1, data: exp_word(ia), err: (ia[1:0] != 2'b00)});
    if (dw) dbg_q.push_back('{due: cyc + 1, data: exp_word(da), err: (da[1:0] != 2'b00)});
    if (r || !dr || dw) waited = 0;
    else if (waited < LIMIT) waited++;
    if_won  = iw;
    dbg_won = dw;
  endtask

  resp_t m_e;
  logic  m_err;
  bit    m_have;

  always @(negedge clk) begin
    if (mon_en) begin
      m_err  = 1'b0;
      m_have = (if_q.size() > 0) && (if_q[0].due == cyc);
      chk("if_rvalid", 32'(if_rvalid), 32'(m_have));
      if (m_have) begin
        m_e = if_q.pop_front();
        if_hold = m_e.data;
        m_err |= m_e.err;
      end
      chk("if_rdata", if_rdata, if_hold);
      m_have = (dbg_q.size() > 0) && (dbg_q[0].due == cyc);
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_have));
      if (m_have) begin
        m_e = dbg_q.pop_front();
        dbg_hold = m_e.data;
        m_err |= m_e.err;
      end
      chk("dbg_rdata", dbg_rdata, dbg_hold);
      chk("addr_err", 32'(addr_err), 32'(m_err));
    end
  end

  bit          cur_ir, cur_dr, r;
  logic [31:0] cur_ia, cur_da;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    // Reset held with IF requesting, then IF streaming
    drive(1, 1, 32'h0, 0, 32'h0);
    mon_en = 1'b1;
    drive(1, 1, 32'h0, 0, 32'h0);
    drive(0, 1, 32'h0, 0, 32'h0);
    drive(0, 1, 32'h4, 0, 32'h0);
    drive(0, 1, 32'h8, 0, 32'h0);
    // Debug alone
    drive(0, 0, 32'h0, 1, 32'h10);
    drive(0, 0, 32'h0, 0, 32'h0);
    // Starvation: debug forced in the fifth contended cycle
    for (int k = 0; k < 4; k++) drive(0, 1, 32'h40 + 32'(4 * k), 1, 32'h20);
    drive(0, 1, 32'h50, 1, 32'h20);
    drive(0, 1, 32'h50, 0, 32'h0);
    // Misaligned IF fetch
    drive(0, 1, 32'h6, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);
    // Debug pending when reset hits
    drive(0, 1, 32'h60, 1, 32'h24);
    drive(1, 0, 32'h0, 1, 32'h24);
    drive(0, 0, 32'h0, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);

    // Random traffic honouring hold-until-grant, with occasional abandons and resets
    cur_ir = 0; cur_dr = 0; cur_ia = '0; cur_da = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!cur_ir || if_won) begin
        cur_ir = ($urandom_range(0, 9) < 7);
        cur_ia = rand_addr();
      end else if ($urandom_range(0, 19) == 0) begin
        cur_ir = 0;
      end
      if (!cur_dr || dbg_won) begin
        cur_dr = ($urandom_range(0, 9) < 5);
        cur_da = rand_addr();
      end else if ($urandom_range(0, 29) == 0) begin
        cur_dr = 0;
      end
      r = ($urandom_range(0, 99) == 0);
      drive(r, cur_ir, cur_ia, cur_dr, cur_da);
    end

    for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
